// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg : constants, state encoding and helpers shared by the UART RX/TX
// Rev 1.0  : initial release
// ---------------------------------------------------------------------------
`default_nettype none

package uart_pkg;

  localparam int CLK_FREQ_DEFAULT = 12_000_000;
  localparam int BAUD_DEFAULT     = 115_200;

  localparam logic [7:0] ASCII_ZERO = 8'h30;
  localparam logic [2:0] NOTE_MAX   = 3'd7;

  typedef enum logic [2:0] {
    RX_IDLE      = 3'd0,
    RX_START     = 3'd1,
    RX_DATA      = 3'd2,
    RX_STOP      = 3'd3,
    RX_WAIT_IDLE = 3'd4
  } rx_state_t;

  function automatic int clks_per_bit(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

  function automatic int half_bit(input int cpb);
    return cpb / 2;
  endfunction

  // True for ASCII '0'..'7', the characters that map onto note codes.
  function automatic logic is_note(input logic [7:0] b);
    return (b >= ASCII_ZERO) && (b <= (ASCII_ZERO + {5'd0, NOTE_MAX}));
  endfunction

endpackage

`default_nettype wire

// File: rtl/rx_sync.sv
// ---------------------------------------------------------------------------
// rx_sync : two-flop synchronizer for an asynchronous input, settable reset value
// Rev 1.0  : initial release
// ---------------------------------------------------------------------------
`default_nettype none

module rx_sync #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_q
);

  logic r_ff1;
  logic r_ff2;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ff1 <= RESET_VAL;
      r_ff2 <= RESET_VAL;
    end else begin
      r_ff1 <= i_d;
      r_ff2 <= r_ff1;
    end
  end

  assign o_q = r_ff2;

endmodule

`default_nettype wire

// File: rtl/uart_rx.sv
// ---------------------------------------------------------------------------
// uart_rx : 8N1 UART receiver with framing-error flag and ASCII '0'..'7' note
//           decode. Define UART_RX_MAJORITY_EN for 2-of-3 majority sampling.
// Rev 1.0  : initial release
// ---------------------------------------------------------------------------
`default_nettype none

module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = CLK_FREQ_DEFAULT,
  parameter int BAUD     = BAUD_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_rx,
  output logic [7:0] o_data,
  output logic       o_valid,
  output logic       o_frame_err,
  output logic       o_busy,
  output logic [2:0] o_note,
  output logic       o_note_valid
);

  localparam int         c_CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD);
  localparam int         c_HALF_BIT     = half_bit(c_CLKS_PER_BIT);
  localparam logic [6:0] c_BIT_LAST     = 7'(c_CLKS_PER_BIT - 1);
  localparam logic [6:0] c_HALF_LAST    = 7'(c_HALF_BIT - 1);

  logic       w_rx_s;
  logic       w_sample;
  rx_state_t  r_state;
  logic [6:0] r_cnt;
  logic [2:0] r_idx;
  logic [7:0] r_shift;

  rx_sync #(
    .RESET_VAL (1'b1)
  ) u_rx_sync (
    .clk (clk),
    .rst (rst),
    .i_d (i_rx),
    .o_q (w_rx_s)
  );

`ifdef UART_RX_MAJORITY_EN
  // Last two synchronized samples; with the current one they form the vote.
  logic [1:0] r_hist;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_hist <= 2'b11;
    end else begin
      r_hist <= {r_hist[0], w_rx_s};
    end
  end

  assign w_sample = (r_hist[1] & r_hist[0]) | (r_hist[1] & w_rx_s) | (r_hist[0] & w_rx_s);
`else
  assign w_sample = w_rx_s;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= RX_IDLE;
      r_cnt        <= 7'd0;
      r_idx        <= 3'd0;
      r_shift      <= 8'd0;
      o_data       <= 8'd0;
      o_valid      <= 1'b0;
      o_frame_err  <= 1'b0;
      o_busy       <= 1'b0;
      o_note       <= 3'd0;
      o_note_valid <= 1'b0;
    end else begin
      o_valid      <= 1'b0;
      o_frame_err  <= 1'b0;
      o_note_valid <= 1'b0;

      case (r_state)
        RX_IDLE: begin
          if (!w_rx_s) begin
            r_state <= RX_START;
            r_cnt   <= 7'd0;
            o_busy  <= 1'b1;
          end
        end

        RX_START: begin
          if (r_cnt == c_HALF_LAST) begin
            r_cnt <= 7'd0;
            if (!w_sample) begin
              r_state <= RX_DATA;
              r_idx   <= 3'd0;
            end else begin
              r_state <= RX_IDLE;
              o_busy  <= 1'b0;
            end
          end else begin
            r_cnt <= r_cnt + 7'd1;
          end
        end

        RX_DATA: begin
          if (r_cnt == c_BIT_LAST) begin
            // LSB arrives first, so shifting right leaves it in bit 0.
            r_shift <= {w_sample, r_shift[7:1]};
            r_cnt   <= 7'd0;
            r_idx   <= r_idx + 3'd1;
            if (r_idx == 3'd7) begin
              r_state <= RX_STOP;
            end
          end else begin
            r_cnt <= r_cnt + 7'd1;
          end
        end

        RX_STOP: begin
          if (r_cnt == c_BIT_LAST) begin
            r_cnt <= 7'd0;
            if (w_sample) begin
              o_data  <= r_shift;
              o_valid <= 1'b1;
              if (is_note(r_shift)) begin
                o_note       <= r_shift[2:0];
                o_note_valid <= 1'b1;
              end
              r_state <= RX_IDLE;
              o_busy  <= 1'b0;
            end else begin
              o_frame_err <= 1'b1;
              r_state     <= RX_WAIT_IDLE;
            end
          end else begin
            r_cnt <= r_cnt + 7'd1;
          end
        end

        RX_WAIT_IDLE: begin
          // A held-low line (break) must not look like a new start bit.
          if (w_rx_s) begin
            r_state <= RX_IDLE;
            o_busy  <= 1'b0;
          end
        end

        default: begin
          r_state <= RX_IDLE;
          o_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_uart_rx.sv
// ---------------------------------------------------------------------------
// tb_uart_rx : directed self-checking bench for uart_rx
// Rev 1.0  : initial release
// ---------------------------------------------------------------------------
`default_nettype none

module tb_uart_rx;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic [7:0] data;
  logic       valid;
  logic       frame_err;
  logic       busy;
  logic [2:0] note;
  logic       note_valid;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  uart_rx dut (
    .clk          (clk),
    .rst          (rst),
    .i_rx         (rx),
    .o_data       (data),
    .o_valid      (valid),
    .o_frame_err  (frame_err),
    .o_busy       (busy),
    .o_note       (note),
    .o_note_valid (note_valid)
  );

  int pcyc = 0;
  always @(posedge clk) pcyc <= pcyc + 1;

  // Output monitor on the falling edge, away from the active edge.
  int   n_valid = 0, n_ferr = 0, n_nv = 0, n_bad = 0;
  int   valid_at = 0, ferr_at = 0, rise_at = 0, fall_at = 0;
  logic prev_busy = 1'b0;

  always @(negedge clk) begin
    if (valid)      begin n_valid++; valid_at = pcyc; end
    if (frame_err)  begin n_ferr++;  ferr_at  = pcyc; end
    if (note_valid) n_nv++;
    if (valid && frame_err)   n_bad++;
    if (note_valid && !valid) n_bad++;
    if (busy && !prev_busy) rise_at = pcyc;
    if (!busy && prev_busy) fall_at = pcyc;
    prev_busy = busy;
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Drives one frame at 104 clk/bit. e0 is the edge that first captures the
  // start bit. glitch_bit inverts one cycle centred on that data bit's sample;
  // rst_bit pulses reset in the middle of that data bit and abandons the frame.
  task automatic send_frame(input logic [7:0] b, input logic stop, input int glitch_bit,
                            input int rst_bit, output int e0);
    logic [9:0] bits;
    bits = {stop, b, 1'b0};
    e0   = pcyc + 1;
    for (int n = 0; n < 10; n++) begin
      for (int c = 0; c < 104; c++) begin
        if (rst_bit >= 0 && n == rst_bit + 1 && c == 52) begin
          rst = 1'b1;
          tick();
          rst = 1'b0;
          rx  = 1'b1;
          return;
        end
        rx = bits[n] ^ ((glitch_bit >= 0) && (n == glitch_bit + 1) && (c == 52));
        tick();
      end
    end
  endtask

  int         e0;
  logic [7:0] glitch_exp;

  initial begin
    rst = 1'b1;
    rx  = 1'b1;
    repeat (3) tick();
    check_eq("rst_data",  {24'd0, data}, 32'h00);
    check_eq("rst_valid", {31'd0, valid}, 32'd0);
    check_eq("rst_ferr",  {31'd0, frame_err}, 32'd0);
    check_eq("rst_busy",  {31'd0, busy}, 32'd0);
    check_eq("rst_note",  {29'd0, note}, 32'd0);
    check_eq("rst_nv",    {31'd0, note_valid}, 32'd0);
    rst = 1'b0;
    repeat (5) tick();

    // '5': note frame, latency and busy edges
    send_frame(8'h35, 1'b1, -1, -1, e0);
    repeat (20) tick();
    check_eq("t1_nvalid",   n_valid, 1);
    check_eq("t1_nnv",      n_nv, 1);
    check_eq("t1_lat",      valid_at - e0, 990);
    check_eq("t1_data",     {24'd0, data}, 32'h35);
    check_eq("t1_note",     {29'd0, note}, 32'd5);
    check_eq("t1_nferr",    n_ferr, 0);
    check_eq("t1_busyrise", rise_at - e0, 2);
    check_eq("t1_busyfall", fall_at, valid_at);

    // 'A': not a note, note holds
    send_frame(8'h41, 1'b1, -1, -1, e0);
    repeat (20) tick();
    check_eq("t2_nvalid", n_valid, 2);
    check_eq("t2_data",   {24'd0, data}, 32'h41);
    check_eq("t2_nnv",    n_nv, 1);
    check_eq("t2_note",   {29'd0, note}, 32'd5);

    // 20-cycle low glitch: rejected at start-bit centre
    e0 = pcyc + 1;
    rx = 1'b0;
    repeat (20) tick();
    rx = 1'b1;
    repeat (80) tick();
    check_eq("t3_busyrise", rise_at - e0, 2);
    check_eq("t3_busyfall", fall_at - e0, 54);
    check_eq("t3_nvalid",   n_valid, 2);
    check_eq("t3_nferr",    n_ferr, 0);
    check_eq("t3_busy",     {31'd0, busy}, 32'd0);

    // framing error followed by a held-low line, then '0'
    send_frame(8'h41, 1'b0, -1, -1, e0);
    rx = 1'b0;
    repeat (300) tick();
    check_eq("t4_nferr",   n_ferr, 1);
    check_eq("t4_ferrlat", ferr_at - e0, 990);
    check_eq("t4_nvalid",  n_valid, 2);
    check_eq("t4_data",    {24'd0, data}, 32'h41);
    check_eq("t4_busyhi",  {31'd0, busy}, 32'd1);
    rx = 1'b1;
    repeat (3) tick();
    check_eq("t4_busylo",  {31'd0, busy}, 32'd0);
    send_frame(8'h30, 1'b1, -1, -1, e0);
    repeat (20) tick();
    check_eq("t4_data30",  {24'd0, data}, 32'h30);
    check_eq("t4_note0",   {29'd0, note}, 32'd0);
    check_eq("t4_nnv",     n_nv, 2);
    check_eq("t4_nvalid2", n_valid, 3);

    // back-to-back '7','0', then reset inside data bit 3 of a third frame
    send_frame(8'h37, 1'b1, -1, -1, e0);
    check_eq("t5_note7",   {29'd0, note}, 32'd7);
    check_eq("t5_nvalid7", n_valid, 4);
    send_frame(8'h30, 1'b1, -1, -1, e0);
    check_eq("t5_note0",   {29'd0, note}, 32'd0);
    check_eq("t5_data0",   {24'd0, data}, 32'h30);
    check_eq("t5_nvalid0", n_valid, 5);
    send_frame(8'h77, 1'b1, -1, 3, e0);
    check_eq("t5_rdata",  {24'd0, data}, 32'h00);
    check_eq("t5_rvalid", {31'd0, valid}, 32'd0);
    check_eq("t5_rferr",  {31'd0, frame_err}, 32'd0);
    check_eq("t5_rbusy",  {31'd0, busy}, 32'd0);
    check_eq("t5_rnote",  {29'd0, note}, 32'd0);
    check_eq("t5_rnv",    {31'd0, note_valid}, 32'd0);
    repeat (1200) tick();
    check_eq("t5_nopulse_v", n_valid, 5);
    check_eq("t5_nopulse_f", n_ferr, 1);
    send_frame(8'h33, 1'b1, -1, -1, e0);
    repeat (20) tick();
    check_eq("t5_data33", {24'd0, data}, 32'h33);
    check_eq("t5_note3",  {29'd0, note}, 32'd3);
    check_eq("t5_nvalid", n_valid, 6);

    // one-cycle inverted glitch exactly on data bit 2's sample point
`ifdef UART_RX_MAJORITY_EN
    glitch_exp = 8'hA5;
`else
    glitch_exp = 8'hA1;
`endif
    send_frame(8'hA5, 1'b1, 2, -1, e0);
    repeat (20) tick();
    check_eq("t6_data",   {24'd0, data}, {24'd0, glitch_exp});
    check_eq("t6_nvalid", n_valid, 7);

    check_eq("excl_pulses", n_bad, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
